// File: rtl/sync_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sync_arb_pkg
// Shared definitions for the synchronising round-robin four-phase arbiter.
//   arb_state_t : arbiter FSM state encoding (exposed for debug/checkers)
//   SYNC_DEPTH  : number of flops in each input synchroniser
// -----------------------------------------------------------------------------
package sync_arb_pkg;

   localparam int SYNC_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_UP = 2'd1,
      ACK_UP = 2'd2,
      REQ_DN = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sync_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// sync_rr_arbiter_if
// Bundle of the requester-side and downstream-side four-phase signals.
//   r_req     : N requests from the requesters (async to clk)
//   a_req     : N acknowledges back to the requesters
//   r0 / a0   : request to / acknowledge from the shared downstream channel
//   grant_idx : index of the current or last granted requester
//   busy      : arbiter is in a transaction
//   state     : arbiter FSM state, for debug and checkers
//
// Handshake: every channel is four-phase return-to-zero. The requesting side
// raises req and holds it until ack rises, then drops req; the acknowledging
// side drops ack only after req has fallen. Neither side may change its wire
// again before seeing the other side's response.
//
// Modports: slave = the arbiter, master = the environment driving it.
// -----------------------------------------------------------------------------
interface sync_rr_arbiter_if
   import sync_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) ();

   logic [N-1:0]  r_req;
   logic [N-1:0]  a_req;
   logic          r0;
   logic          a0;
   logic [IW-1:0] grant_idx;
   logic          busy;
   arb_state_t    state;

   modport slave (
      input  r_req, a0,
      output a_req, r0, grant_idx, busy, state
   );

   modport master (
      output r_req, a0,
      input  a_req, r0, grant_idx, busy, state
   );

endinterface

// File: rtl/sync_rr_arbiter_dualffsync.sv
// -----------------------------------------------------------------------------
// dualffsync
// Flop-chain synchroniser for one asynchronous single-bit input.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears the chain
//   d       : asynchronous input
//   q       : synchronised output, SYNC_DEPTH clk edges behind d
// -----------------------------------------------------------------------------
module dualffsync
   import sync_arb_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [SYNC_DEPTH-1:0] chain;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_DEPTH-2:0], d};
      end
   end

   assign q = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/sync_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sync_rr_arbiter
// Arbitrates N asynchronous four-phase requesters onto one shared four-phase
// downstream channel, round-robin, one transaction at a time.
//   clk     : sampling clock for all internal state
//   reset_n : asynchronous active-low reset
//   bus     : sync_rr_arbiter_if slave modport (r_req, a0 in; a_req, r0,
//             grant_idx, busy, state out; all outputs registered)
// -----------------------------------------------------------------------------
module sync_rr_arbiter
   import sync_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input logic              clk,
   input logic              reset_n,
   sync_rr_arbiter_if.slave bus
);

   // Synchronised copies of the asynchronous inputs; nothing else reads the
   // raw r_req / a0 wires.
   logic [N-1:0] r_s;
   logic         a0_s;

   for (genvar i = 0; i < N; i++) begin : g_req_sync
      dualffsync u_req_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (bus.r_req[i]),
         .q       (r_s[i])
      );
   end

   dualffsync u_a0_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.a0),
      .q       (a0_s)
   );

   arb_state_t    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] grant_q, grant_d;
   logic          r0_q, r0_d;
   logic [N-1:0]  a_req_q, a_req_d;
   logic          busy_q, busy_d;

   logic          any_req;
   logic [IW-1:0] winner;

   // Round-robin pick: scan ptr, ptr+1, ... with wrap. Scanning from the far
   // end downward lets the closest hit to ptr overwrite the others.
   always_comb begin
      int idx;
      idx     = 0;
      winner  = ptr_q;
      any_req = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % N;
         if (r_s[idx]) begin
            winner  = IW'(idx);
            any_req = 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req)         state_d = REQ_UP;
         REQ_UP:  if (a0_s)            state_d = ACK_UP;
         ACK_UP:  if (!r_s[grant_q])   state_d = REQ_DN;
         REQ_DN:  if (!a0_s)           state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and pointer; each changes on the
   // same edge as the state transition it belongs to.
   always_comb begin
      ptr_d   = ptr_q;
      grant_d = grant_q;
      r0_d    = r0_q;
      a_req_d = a_req_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               r0_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         REQ_UP: begin
            if (a0_s) begin
               a_req_d          = '0;
               a_req_d[grant_q] = 1'b1;
            end
         end
         ACK_UP: begin
            if (!r_s[grant_q]) begin
               r0_d = 1'b0;
            end
         end
         REQ_DN: begin
            if (!a0_s) begin
               a_req_d = '0;
               ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
               busy_d  = 1'b0;
            end
         end
         default: begin
            a_req_d = '0;
         end
      endcase
   end

   // Single register process for FSM, pointer and outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         r0_q    <= 1'b0;
         a_req_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         r0_q    <= r0_d;
         a_req_q <= a_req_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.a_req     = a_req_q;
   assign bus.r0        = r0_q;
   assign bus.grant_idx = grant_q;
   assign bus.busy      = busy_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_rr_arbiter
// Directed self-checking bench for sync_rr_arbiter (N=4). The bench plays both
// the requesters and the downstream channel. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sync_rr_arbiter;
   import sync_arb_pkg::*;

   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int TMO = 40;

   logic clk;
   logic reset_n;

   int n_checks;
   int n_pass;

   sync_rr_arbiter_if #(.N(N), .IW(IW)) bus ();

   sync_rr_arbiter #(.N(N), .IW(IW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] bit_of(input int g);
      logic [N-1:0] v;
      v    = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_r0(input logic v, input string tag);
      for (int i = 0; i < TMO && bus.r0 !== v; i++) @(negedge clk);
      check(tag, bus.r0, v);
   endtask

   task automatic wait_areq(input logic [N-1:0] v, input string tag);
      for (int i = 0; i < TMO && bus.a_req !== v; i++) @(negedge clk);
      check(tag, bus.a_req, v);
   endtask

   // One full four-phase transaction for the expected winner. drop_all
   // withdraws every pending request together with the winner's.
   task automatic serve(input int exp_g, input bit drop_all, input string tag);
      wait_r0(1'b1, {tag, "_r0_up"});
      check({tag, "_grant"}, bus.grant_idx, exp_g);
      check({tag, "_busy"}, bus.busy, 1);
      bus.a0 = 1'b1;
      wait_areq(bit_of(exp_g), {tag, "_ack_up"});
      if (drop_all) bus.r_req = '0;
      else          bus.r_req[exp_g] = 1'b0;
      wait_r0(1'b0, {tag, "_r0_dn"});
      bus.a0 = 1'b0;
      wait_areq('0, {tag, "_ack_dn"});
   endtask

   // a_req must never be multi-hot; watched during the contention run.
   bit mon_en;
   always @(negedge clk) begin
      if (mon_en) check("onehot0", $onehot0(bus.a_req), 1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int seq [5];
      seq      = '{0, 1, 2, 3, 0};
      n_checks = 0;
      n_pass   = 0;
      mon_en   = 1'b0;
      reset_n  = 1'b0;
      bus.r_req = '0;
      bus.a0    = 1'b0;
      #1;
      check("rst_r0", bus.r0, 0);
      check("rst_areq", bus.a_req, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_grant", bus.grant_idx, 0);
      check("rst_state", bus.state, IDLE);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Contention from ptr=0: 0,1,2,3,0 with winners re-requesting.
      mon_en    = 1'b1;
      bus.r_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         serve(seq[i], i == 4, $sformatf("cont%0d", i));
         if (i < 4) bus.r_req[seq[i]] = 1'b1;
      end
      mon_en = 1'b0;
      repeat (4) @(negedge clk);
      check("cont_idle", bus.state, IDLE);

      // Late arrival: ptr=1, requester 1 granted, requester 2 shows up in ACK_UP.
      bus.r_req = 4'b0010;
      wait_r0(1'b1, "late_r0_up");
      check("late_grant", bus.grant_idx, 1);
      bus.a0 = 1'b1;
      wait_areq(4'b0010, "late_ack_up");
      check("late_state", bus.state, ACK_UP);
      bus.r_req[2] = 1'b1;
      repeat (6) @(negedge clk);
      check("late_hold", {bus.grant_idx, bus.a_req, bus.r0}, {2'd1, 4'b0010, 1'b1});
      bus.r_req[1] = 1'b0;
      wait_r0(1'b0, "late_r0_dn");
      bus.a0 = 1'b0;
      wait_areq('0, "late_ack_dn");
      serve(2, 1'b0, "late2");

      // Wrap: ptr=3, requests 3 and 0.
      bus.r_req = 4'b1001;
      serve(3, 1'b0, "wrap3");
      serve(0, 1'b0, "wrap0");
      repeat (4) @(negedge clk);

      // Single with exact latency counts (ptr=1 now).
      bus.r_req = 4'b0001;
      @(negedge clk); check("lat_r0_e1", bus.r0, 0);
      @(negedge clk); check("lat_r0_e2", bus.r0, 0);
      @(negedge clk); check("lat_r0_e3", bus.r0, 1);
      check("single_grant", bus.grant_idx, 0);
      check("single_state", bus.state, REQ_UP);
      repeat (2) @(negedge clk);
      bus.a0 = 1'b1;
      @(negedge clk); check("lat_ack_e1", bus.a_req, 0);
      @(negedge clk); check("lat_ack_e2", bus.a_req, 0);
      @(negedge clk); check("lat_ack_e3", bus.a_req, 4'b0001);
      bus.r_req = '0;
      wait_r0(1'b0, "single_r0_dn");
      bus.a0 = 1'b0;
      wait_areq('0, "single_ack_dn");
      @(negedge clk);
      check("single_busy_end", bus.busy, 0);
      check("single_grant_hold", bus.grant_idx, 0);
      repeat (3) @(negedge clk);
      // ptr should now be 1: requester 1 beats requester 0.
      bus.r_req = 4'b0011;
      serve(1, 1'b0, "ptr1");
      serve(0, 1'b0, "ptr1b");
      repeat (4) @(negedge clk);

      // Reset mid-transaction in ACK_UP.
      bus.r_req = 4'b0001;
      wait_r0(1'b1, "mid_r0_up");
      bus.a0 = 1'b1;
      wait_areq(4'b0001, "mid_ack_up");
      check("mid_state", bus.state, ACK_UP);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out", {bus.r0, bus.a_req, bus.busy}, {1'b0, 4'b0000, 1'b0});
      check("mid_rst_state", bus.state, IDLE);
      bus.r_req = '0;
      bus.a0    = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // After reset: requester 2 granted; a0 stalled 100 cycles in REQ_UP.
      bus.r_req = 4'b0100;
      wait_r0(1'b1, "post_r0_up");
      check("post_grant", bus.grant_idx, 2);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("stall", {bus.state, bus.r0, bus.a_req}, {REQ_UP, 1'b1, 4'b0000});
      end
      bus.a0 = 1'b1;
      wait_areq(4'b0100, "post_ack_up");
      bus.r_req = '0;
      wait_r0(1'b0, "post_r0_dn");
      bus.a0 = 1'b0;
      wait_areq('0, "post_ack_dn");
      @(negedge clk);
      check("post_busy_end", bus.busy, 0);
      check("post_state_end", bus.state, IDLE);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
